// File: rtl/porownanie_sync.sv
// ---------------------------------------------------------------------------
// porownanie_sync
//
// Registered signed comparator. It reports whether operand A is strictly
// greater than operand B. Both operands are two's complement. The flag is
// captured into a single output register on every rising edge of i_clk.
// There is no enable and no handshake.
//
// Parameters:
//   BITS      operand width, legal range 2..64 (default 32)
//
// Ports:
//   i_clk     system clock, rising-edge active
//   i_rst     asynchronous, active-high reset; forces o_result to 0
//   i_arg_A   operand A, two's complement, BITS wide
//   i_arg_B   operand B, two's complement, BITS wide
//   o_result  registered flag: 1 when $signed(A) > $signed(B), else 0
// ---------------------------------------------------------------------------
module porownanie_sync #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic            o_result
);

    localparam int MAG = BITS - 1;

    // Per-bit terms of the magnitude compare:
    //   bit_diff[i] means the operands differ at bit i.
    //   bit_gt[i]   means A has a 1 and B has a 0 at bit i.
    logic [MAG-1:0] bit_diff;
    logic [MAG-1:0] bit_gt;

    genvar gi;
    generate
        for (gi = 0; gi < MAG; gi++) begin : g_bit
            assign bit_diff[gi] = i_arg_A[gi] ^ i_arg_B[gi];
            assign bit_gt[gi]   = i_arg_A[gi] & ~i_arg_B[gi];
        end
    endgenerate

    logic sign_a;
    logic sign_b;
    assign sign_a = i_arg_A[BITS-1];
    assign sign_b = i_arg_B[BITS-1];

    // Scan the magnitude bits MSB first. The first differing bit decides the
    // result, and later bits are ignored once a decision is made. When both
    // signs are equal, an unsigned compare of the lower bits gives the signed
    // order. This holds for two negatives too, because a larger low part
    // means a value closer to zero.
    logic mag_gt;
    logic decided;

    always_comb begin
        mag_gt  = 1'b0;
        decided = 1'b0;
        for (int i = MAG - 1; i >= 0; i--) begin
            if (!decided && bit_diff[i]) begin
                mag_gt  = bit_gt[i];
                decided = 1'b1;
            end
        end
    end

    // If the signs differ, A is greater exactly when A is non-negative.
    // Equal operands leave mag_gt at 0, so the compare is strict.
    logic result_d;
    logic result_q;

    always_comb begin
        result_d = 1'b0;
        if (sign_a != sign_b) begin
            result_d = ~sign_a;
        end else begin
            result_d = mag_gt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= 1'b0;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_porownanie_sync.sv
// ---------------------------------------------------------------------------
// tb_porownanie_sync
//
// Self-checking bench for porownanie_sync with BITS=32. Each applied operand
// pair pushes its expected flag onto a scoreboard queue. The bench pops and
// compares that flag one edge later. Reset behaviour is checked directly.
// ---------------------------------------------------------------------------
module tb_porownanie_sync;

    localparam int BITS = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] arg_a;
    logic [BITS-1:0] arg_b;
    logic            result;

    int n_vec = 0;
    int n_bad = 0;
    bit exp_q[$];

    porownanie_sync #(.BITS(BITS)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_arg_A (arg_a),
        .i_arg_B (arg_b),
        .o_result(result)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b", tag, got, exp);
        end else begin
            $display("ok   %s: %0b", tag, got);
        end
    endtask

    // Drive one operand pair and push its expected flag. Then wait for the
    // capturing edge, pop the flag and compare it with o_result.
    task automatic apply(input string tag, input logic [BITS-1:0] av,
                         input logic [BITS-1:0] bv);
        bit e;
        arg_a = av;
        arg_b = bv;
        exp_q.push_back($signed(av) > $signed(bv));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_bit({tag, "_underflow"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check_bit($sformatf("%s A=%h B=%h", tag, av, bv), result, e);
        end
    endtask

    initial begin
        logic [BITS-1:0] ra;
        logic [BITS-1:0] rb;

        // Hold reset with operands that would give 1.
        rst   = 1'b1;
        arg_a = 32'h0000_0000;
        arg_b = 32'hFFFF_FFFF;
        #1;
        check_bit("reset_t0", result, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_bit($sformatf("reset_hold%0d", i), result, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        apply("release", 32'h0000_0000, 32'hFFFF_FFFF);

        // Sign boundaries from zero.
        for (int i = 0; i < 5; i++) begin
            apply("zero_vs_neg", 32'h0000_0000,
                  (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000);
        end

        // Most-negative A.
        for (int i = 0; i < 5; i++) begin
            apply("min_a", 32'h8000_0000,
                  (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000);
        end

        apply("max_vs_min", 32'h7FFF_FFFF, 32'h8000_0000);
        apply("five_seven", 32'h0000_0005, 32'h0000_0007);
        apply("neg_mag",    32'hFFFF_FFFE, 32'hFFFF_FFFD);
        apply("equal",      32'h1234_5678, 32'h1234_5678);
        apply("min_vs_max", 32'h8000_0000, 32'h7FFF_FFFF);

        // Operand changes between edges must not reach o_result.
        apply("pre_hold", 32'h0000_0009, 32'h0000_0003);
        arg_a = 32'h0000_0001;
        arg_b = 32'h0000_0002;
        #2;
        check_bit("hold_between_edges", result, 1'b1);

        // Pulse an asynchronous reset between edges while o_result is 1.
        @(negedge clk);
        apply("pre_async", 32'h0000_0001, 32'hFFFF_FFF0);
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_drop", result, 1'b0);
        @(posedge clk);
        #1;
        check_bit("async_held", result, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_async", 32'h0000_0005, 32'h0000_0007);
        apply("post_async2", 32'h7FFF_FFFF, 32'h8000_0000);

        // Assert reset at a rising edge; reset must win.
        arg_a = 32'h0000_0010;
        arg_b = 32'h0000_0001;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check_bit("rst_at_edge", result, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply("after_edge_rst", 32'h0000_0010, 32'h0000_0001);

        // Random pairs, one per cycle. Every fourth pair forces equal signs.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb[BITS-1] = ra[BITS-1];
            if (i % 8 == 5) rb = ra;
            apply($sformatf("rand%0d", i), ra, rb);
        end

        if (exp_q.size() != 0) begin
            check_bit("queue_empty", 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
